// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the dmem/MMIO responder: register map, STATUS layout, decode prefix.
// No logic; imported by the interface, top and TX FIFO.
package dmem_mmio_pkg;

    localparam logic [7:0]  MMIO_PREFIX  = 8'hFF;

    localparam logic [11:0] ADDR_TX_DATA = 12'hFF0;
    localparam logic [11:0] ADDR_STATUS  = 12'hFF1;
    localparam logic [11:0] ADDR_CYCLES  = 12'hFF2;
    localparam logic [11:0] ADDR_SCRATCH = 12'hFF3;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_OCC_LSB = 8;
    localparam int STAT_OCC_W   = 8;

    function automatic logic is_mmio(input logic [11:0] addr);
        return addr[11:4] == MMIO_PREFIX;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Processor data port, dmem syncram port and TX byte stream bundled as one bus.
// slave = responder view, master = processor/memory/consumer environment view.
interface dmem_mmio_responder_if;
    logic [11:0] cpu_address;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic [31:0] cpu_q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  cpu_address, cpu_data, cpu_wren, mem_q, tx_ready,
        output cpu_q, mem_address, mem_data, mem_wren, tx_data, tx_valid
    );

    modport master (
        output cpu_address, cpu_data, cpu_wren, mem_q, tx_ready,
        input  cpu_q, mem_address, mem_data, mem_wren, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Byte FIFO for the TX stream; head is registered storage at the read pointer, push visible next cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle; otherwise the caller sees it dropped.
module tx_fifo #(
    parameter int TX_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [7:0]                  push_data,
    input  logic                        pop,
    output logic [7:0]                  head,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(TX_DEPTH):0]   count
);
    localparam int PW = $clog2(TX_DEPTH);

    logic [7:0]    store_q [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(TX_DEPTH));
    assign count = count_q;
    assign head  = store_q[rd_ptr_q];

    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is reset too so tx_data reads 0 out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TX_DEPTH; i++) store_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) store_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem passthrough with MMIO block at 0xFF0-0xFFF; one-cycle read latency for both paths. Optional macro MMIO_CYCLE_COUNTER_EN.
// TX stream is valid/ready; tx_valid depends only on registered FIFO state, writes to a full FIFO drop and set overflow.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    dmem_mmio_responder_if.slave     bus
);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          mmio_hit, mmio_wr;
    logic          push, pop, status_wr, drop;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [31:0]   status, cycles, rd_val;

    logic          ovf_q, ovf_d;
    logic [31:0]   scratch_q, scratch_d;
    logic          sel_q;
    logic [31:0]   mmio_q;

    assign mmio_hit        = is_mmio(bus.cpu_address);
    assign mmio_wr         = bus.cpu_wren & mmio_hit;
    assign bus.mem_address = bus.cpu_address;
    assign bus.mem_data    = bus.cpu_data;
    assign bus.mem_wren    = bus.cpu_wren & ~mmio_hit;

    assign push      = mmio_wr & (bus.cpu_address == ADDR_TX_DATA);
    assign status_wr = mmio_wr & (bus.cpu_address == ADDR_STATUS);
    assign pop       = bus.tx_valid & bus.tx_ready;
    assign drop      = push & fifo_full & ~pop;

    tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.cpu_data[7:0]),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign bus.tx_valid = ~fifo_empty;
    assign bus.tx_data  = fifo_head;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_q + 32'd1;
    end
    assign cycles = cyc_q;
`else
    assign cycles = '0;
`endif

    always_comb begin
        status                                = '0;
        status[STAT_EMPTY]                    = fifo_empty;
        status[STAT_FULL]                     = fifo_full;
        status[STAT_OVF]                      = ovf_q;
        status[STAT_OCC_LSB +: STAT_OCC_W]    = STAT_OCC_W'(fifo_count);
    end

    // Read value is taken from pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        case (bus.cpu_address)
            ADDR_STATUS:  rd_val = status;
            ADDR_CYCLES:  rd_val = cycles;
            ADDR_SCRATCH: rd_val = scratch_q;
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        ovf_d     = ovf_q;
        scratch_d = scratch_q;
        if (status_wr) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
        if (mmio_wr && bus.cpu_address == ADDR_SCRATCH) scratch_d = bus.cpu_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q     <= 1'b0;
            scratch_q <= '0;
            sel_q     <= 1'b0;
            mmio_q    <= '0;
        end else begin
            ovf_q     <= ovf_d;
            scratch_q <= scratch_d;
            sel_q     <= mmio_hit;
            mmio_q    <= rd_val;
        end
    end

    assign bus.cpu_q = sel_q ? mmio_q : bus.mem_q;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a behavioural one-cycle dmem syncram.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_dmem_mmio_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(.TX_DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] dmem [0:4095];
    logic [31:0] mem_q_r = 32'h0;
    initial for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
    always @(posedge clock) begin
        if (bus.mem_wren) dmem[bus.mem_address] <= bus.mem_data;
        mem_q_r <= dmem[bus.mem_address];
    end
    assign bus.mem_q = mem_q_r;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        bus.cpu_address = a;
        bus.cpu_data    = d;
        bus.cpu_wren    = 1'b1;
        cyc();
        bus.cpu_wren    = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d);
        bus.cpu_address = a;
        bus.cpu_wren    = 1'b0;
        cyc();
        d = bus.cpu_q;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        bus.cpu_address = 12'h000;
        bus.cpu_data    = 32'h0;
        bus.cpu_wren    = 1'b0;
        bus.tx_ready    = 1'b0;
        reset = 1'b0;
        repeat (3) cyc();
        n_total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0b want 0", bus.tx_valid);
        else n_pass++;
        n_total++;
        if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", bus.tx_data);
        else n_pass++;
        n_total++;
        if (bus.cpu_q !== 32'h0) $display("FAIL reset_cpu_q got %h want 00000000", bus.cpu_q);
        else n_pass++;
        reset = 1'b1;
        cyc();
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000001) $display("FAIL reset_status got %h want 00000001", r);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        logic [31:0] r;
        bus.cpu_address = 12'h010;
        bus.cpu_data    = 32'h12345678;
        bus.cpu_wren    = 1'b1;
        #1;
        n_total++;
        if (bus.mem_wren !== 1'b1 || bus.mem_address !== 12'h010 || bus.mem_data !== 32'h12345678)
            $display("FAIL pass_wr got wren=%0b addr=%h data=%h want 1/010/12345678",
                     bus.mem_wren, bus.mem_address, bus.mem_data);
        else n_pass++;
        cyc();
        bus.cpu_wren = 1'b0;
        do_read(12'h010, r);
        n_total++;
        if (r !== 32'h12345678) $display("FAIL pass_rd got %h want 12345678", r);
        else n_pass++;
        bus.cpu_address = 12'hFF3;
        bus.cpu_data    = 32'hCAFEF00D;
        bus.cpu_wren    = 1'b1;
        #1;
        n_total++;
        if (bus.mem_wren !== 1'b0) $display("FAIL scratch_mem_wren got %0b want 0", bus.mem_wren);
        else n_pass++;
        cyc();
        bus.cpu_wren = 1'b0;
        do_read(12'hFF3, r);
        n_total++;
        if (r !== 32'hCAFEF00D) $display("FAIL scratch_rd got %h want cafef00d", r);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] r;
        bus.tx_ready = 1'b0;
        do_write(12'hFF0, 32'h00000041);
        n_total++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41)
            $display("FAIL stream_first got v=%0b d=%h want 1/41", bus.tx_valid, bus.tx_data);
        else n_pass++;
        do_write(12'hFF0, 32'h00000042);
        do_write(12'hFF0, 32'h00000043);
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000300) $display("FAIL stream_status3 got %h want 00000300", r);
        else n_pass++;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i))
                $display("FAIL stream_byte%0d got v=%0b d=%h want 1/%h", i, bus.tx_valid, bus.tx_data, 8'(8'h41 + i));
            else n_pass++;
            cyc();
        end
        n_total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL stream_drained got %0b want 0", bus.tx_valid);
        else n_pass++;
        bus.tx_ready = 1'b0;
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000001) $display("FAIL stream_status_empty got %h want 00000001", r);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_write(12'hFF0, 32'(8'h60 + i));
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000806) $display("FAIL ovf_status got %h want 00000806", r);
        else n_pass++;
        do_write(12'hFF1, 32'h0);
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000802) $display("FAIL ovf_cleared got %h want 00000802", r);
        else n_pass++;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h60 + i))
                $display("FAIL ovf_byte%0d got v=%0b d=%h want 1/%h", i, bus.tx_valid, bus.tx_data, 8'(8'h60 + i));
            else n_pass++;
            cyc();
        end
        n_total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL ovf_ninth_emitted got v=%0b d=%h want v=0", bus.tx_valid, bus.tx_data);
        else n_pass++;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [31:0] r;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(12'hFF0, 32'(8'h70 + i));
        bus.tx_ready = 1'b1;
        n_total++;
        if (bus.tx_data !== 8'h70) $display("FAIL fullpop_head got %h want 70", bus.tx_data);
        else n_pass++;
        do_write(12'hFF0, 32'h00000055);
        bus.tx_ready = 1'b0;
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000802) $display("FAIL fullpop_status got %h want 00000802", r);
        else n_pass++;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'h55 : 8'(8'h71 + i);
            n_total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp)
                $display("FAIL fullpop_byte%0d got v=%0b d=%h want 1/%h", i, bus.tx_valid, bus.tx_data, exp);
            else n_pass++;
            cyc();
        end
        n_total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL fullpop_drained got %0b want 0", bus.tx_valid);
        else n_pass++;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_cycles();
        logic [31:0] a, b;
        do_read(12'hFF2, a);
        repeat (9) cyc();
        do_read(12'hFF2, b);
`ifdef MMIO_CYCLE_COUNTER_EN
        n_total++;
        if (b - a !== 32'd10) $display("FAIL cycles_delta got %0d want 10", b - a);
        else n_pass++;
`else
        n_total++;
        if (a !== 32'h0) $display("FAIL cycles_off_a got %h want 00000000", a);
        else n_pass++;
        n_total++;
        if (b !== 32'h0) $display("FAIL cycles_off_b got %h want 00000000", b);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        do_write(12'h020, 32'hAAAA5555);
        do_write(12'hFF5, 32'h11111111);
        bus.cpu_address = 12'h020;
        cyc();
        n_total++;
        if (bus.cpu_q !== 32'hAAAA5555) $display("FAIL b2b_mem got %h want aaaa5555", bus.cpu_q);
        else n_pass++;
        bus.cpu_address = 12'hFF3;
        cyc();
        n_total++;
        if (bus.cpu_q !== 32'hCAFEF00D) $display("FAIL b2b_scratch got %h want cafef00d", bus.cpu_q);
        else n_pass++;
        bus.cpu_address = 12'h010;
        cyc();
        n_total++;
        if (bus.cpu_q !== 32'h12345678) $display("FAIL b2b_mem2 got %h want 12345678", bus.cpu_q);
        else n_pass++;
        do_read(12'hFF5, r);
        n_total++;
        if (r !== 32'h0) $display("FAIL unmapped_rd got %h want 00000000", r);
        else n_pass++;
        do_read(12'hFF0, r);
        n_total++;
        if (r !== 32'h0) $display("FAIL txdata_rd got %h want 00000000", r);
        else n_pass++;
        bus.tx_ready = 1'b0;
        bus.cpu_address = 12'hFF1;
        bus.cpu_data    = 32'h000000AB;
        bus.cpu_wren    = 1'b0;
        do_write(12'hFF0, 32'h000000AB);
        n_total++;
        if (bus.cpu_q !== 32'h0) $display("FAIL txwr_rd_value got %h want 00000000", bus.cpu_q);
        else n_pass++;
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000100) $display("FAIL status_after_push got %h want 00000100", r);
        else n_pass++;
        bus.tx_ready = 1'b1;
        cyc();
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(12'hFF0, 32'(8'h90 + i));
        do_read(12'hFF3, r);
        n_total++;
        if (bus.tx_valid !== 1'b1 || r !== 32'hCAFEF00D)
            $display("FAIL mid_pre got v=%0b q=%h want 1/cafef00d", bus.tx_valid, r);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.tx_valid !== 1'b0) $display("FAIL mid_tx_valid got %0b want 0", bus.tx_valid);
        else n_pass++;
        n_total++;
        if (bus.cpu_q !== bus.mem_q || bus.cpu_q !== 32'h0)
            $display("FAIL mid_cpu_q got %h want mem_q %h", bus.cpu_q, bus.mem_q);
        else n_pass++;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        do_read(12'hFF1, r);
        n_total++;
        if (r !== 32'h00000001) $display("FAIL mid_status got %h want 00000001", r);
        else n_pass++;
        do_read(12'hFF3, r);
        n_total++;
        if (r !== 32'h0) $display("FAIL mid_scratch got %h want 00000000", r);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_stream();
        test_overflow();
        test_full_pop();
        test_cycles();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
